// File: rtl/core_defs.sv
// Shared memory-access definitions: access width codes, responder FSM states
// and byte-mask / alignment helpers used by the execute stage and data memory.
package core_defs;

    localparam logic [1:0] MEM_ACC_8   = 2'b00;
    localparam logic [1:0] MEM_ACC_16  = 2'b01;
    localparam logic [1:0] MEM_ACC_32  = 2'b10;
    localparam logic [1:0] MEM_ACC_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_RESP     = 2'd2,
        ST_WAIT_REL = 2'd3
    } mem_state_t;

    // The reserved code behaves exactly like a full word access.
    function automatic logic [3:0] acc_byte_mask(input logic [1:0] width);
        logic [3:0] mask;
        case (width)
            MEM_ACC_8:  mask = 4'b0001;
            MEM_ACC_16: mask = 4'b0011;
            default:    mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic acc_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic bad;
        case (width)
            MEM_ACC_8:  bad = 1'b0;
            MEM_ACC_16: bad = addr_lo[0];
            default:    bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_sel.sv
// Byte-lane extraction (zero-extended load data) and store-lane merge for a
// little-endian access of 1, 2 or 4 bytes.
module mem_lane_sel
    import core_defs::*;
#(
    parameter int M_WIDTH = 32
) (
    input  logic [1:0]         i_width,
    input  logic [31:0]        i_rd_bytes,
    input  logic [31:0]        i_wr_data,
    output logic [M_WIDTH-1:0] o_ld_data,
    output logic [31:0]        o_wr_bytes,
    output logic [3:0]         o_byte_en
);

    logic [3:0]  w_mask;
    logic [31:0] w_ld_bytes;

    assign w_mask = acc_byte_mask(i_width);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_ld_bytes[gi*8 +: 8] = w_mask[gi] ? i_rd_bytes[gi*8 +: 8] : 8'h00;
            assign o_wr_bytes[gi*8 +: 8] = i_wr_data[gi*8 +: 8];
        end
    endgenerate

    assign o_ld_data = M_WIDTH'(w_ld_bytes);
    assign o_byte_en = w_mask;

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory with fixed-latency request/ready handshake.
// Optional misalignment fault reporting is enabled by defining MEM_MISALIGN_CHK_EN.
module data_mem_responder
    import core_defs::*;
#(
    parameter int M_WIDTH     = 32,
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [M_WIDTH-1:0] mem_addr,
    input  logic [M_WIDTH-1:0] mem_data_out,
    input  logic [1:0]         mem_acc_width,
    output logic [M_WIDTH-1:0] mem_data_in,
    output logic               mem_ready,
    output logic               mem_err
);

    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    mem_state_t r_state;
    mem_state_t w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_addr_lo;
    logic [31:0]   r_wdata;
    logic [1:0]    r_width;
    logic [M_WIDTH-1:0] r_data_in;

    logic [7:0] r_mem [DEPTH_BYTES];

    logic          w_accept;
    logic          w_commit;
    logic          w_cur_we;
    logic [AW-1:0] w_cur_addr;
    logic [1:0]    w_cur_addr_lo;
    logic [31:0]   w_cur_wdata;
    logic [1:0]    w_cur_width;
    logic          w_misalign;
    logic          w_do_write;
    logic [AW-1:0] w_lane_idx [4];
    logic [31:0]   w_rd_bytes;
    logic [31:0]   w_wr_bytes;
    logic [3:0]    w_byte_en;
    logic [M_WIDTH-1:0] w_ld_data;

    assign w_accept = (r_state == ST_IDLE) && mem_req;

    // With LATENCY = 1 the access happens on the accepting edge itself,
    // so the live inputs stand in for the not-yet-latched copies.
    assign w_commit = ((r_state == ST_BUSY) && (r_cnt == '0)) || (w_accept && (LATENCY == 1));

    assign w_cur_we      = (r_state == ST_IDLE) ? mem_we                 : r_we;
    assign w_cur_addr    = (r_state == ST_IDLE) ? mem_addr[AW-1:0]       : r_addr;
    assign w_cur_addr_lo = (r_state == ST_IDLE) ? mem_addr[1:0]          : r_addr_lo;
    assign w_cur_wdata   = (r_state == ST_IDLE) ? mem_data_out[31:0]     : r_wdata;
    assign w_cur_width   = (r_state == ST_IDLE) ? mem_acc_width          : r_width;

`ifdef MEM_MISALIGN_CHK_EN
    assign w_misalign = acc_misaligned(w_cur_width, w_cur_addr_lo);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_do_write = w_commit && w_cur_we && !w_misalign && !rst;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    if (LATENCY == 1) begin
                        w_state_next = ST_RESP;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = ST_BUSY;
                        w_cnt_next   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_state_next = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!mem_req) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_we      <= mem_we;
            r_addr    <= mem_addr[AW-1:0];
            r_addr_lo <= mem_addr[1:0];
            r_wdata   <= mem_data_out[31:0];
            r_width   <= mem_acc_width;
        end
    end

    // Each lane wraps independently so a word straddling the top of memory
    // continues at byte 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_addr
            assign w_lane_idx[gi] = w_cur_addr + AW'(gi);
            assign w_rd_bytes[gi*8 +: 8] = r_mem[w_lane_idx[gi]];
        end
    endgenerate

    mem_lane_sel #(
        .M_WIDTH (M_WIDTH)
    ) u_lane_sel (
        .i_width    (w_cur_width),
        .i_rd_bytes (w_rd_bytes),
        .i_wr_data  (w_cur_wdata),
        .o_ld_data  (w_ld_data),
        .o_wr_bytes (w_wr_bytes),
        .o_byte_en  (w_byte_en)
    );

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_lane_idx[i]] <= w_wr_bytes[i*8 +: 8];
                end
            end
        end
    end

    // Response data is captured on the edge entering RESP and cleared on the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_in <= '0;
        end else if (w_commit && !w_cur_we && !w_misalign) begin
            r_data_in <= w_ld_data;
        end else begin
            r_data_in <= '0;
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_commit && w_misalign;
        end
    end

    assign mem_err = r_err;
`else
    assign mem_err = 1'b0;
`endif

    assign mem_ready   = (r_state == ST_RESP);
    assign mem_data_in = r_data_in;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array
// reference model; honours MEM_MISALIGN_CHK_EN the same way as the design.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic [1:0]  mem_acc_width;
    logic [31:0] mem_data_in;
    logic        mem_ready;
    logic        mem_err;

    logic [7:0] ref_mem [256];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .M_WIDTH     (32),
        .DEPTH_BYTES (256),
        .LATENCY     (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_data_out  (mem_data_out),
        .mem_acc_width (mem_acc_width),
        .mem_data_in   (mem_data_in),
        .mem_ready     (mem_ready),
        .mem_err       (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit misaligned(input logic [1:0] w, input logic [31:0] addr);
`ifdef MEM_MISALIGN_CHK_EN
        if (w == 2'b00) return 1'b0;
        if (w == 2'b01) return addr[0];
        return addr[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_idx(input logic [31:0] addr, input int i);
        return int'((addr + 32'(i)) & 32'h0000_00FF);
    endfunction

    // One complete handshake; inputs are scrambled while the access is in flight.
    task automatic access(input bit we, input logic [1:0] w, input logic [31:0] addr,
                          input logic [31:0] data, input int hold,
                          output logic [31:0] got_data, output bit got_err);
        int n;
        bit bad;
        logic [31:0] exp_d;
        int cyc;
        bit seen;
        n = nbytes(w);
        bad = misaligned(w, addr);
        exp_d = '0;
        cyc = 0;
        seen = 1'b0;
        if (!we && !bad)
            for (int i = 0; i < n; i++) exp_d[i*8 +: 8] = ref_mem[ref_idx(addr, i)];
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_data_out = data; mem_acc_width = w;
        @(posedge clk); #1;
        check("busy_ready", 32'(mem_ready), 32'd0);
        check("busy_data", mem_data_in, 32'd0);
        mem_we = 1'($urandom_range(0, 1));
        mem_addr = $urandom;
        mem_data_out = $urandom;
        mem_acc_width = 2'($urandom_range(0, 3));
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_ready) seen = 1'b1;
        end
        check("latency", 32'(cyc), 32'(LAT));
        got_data = mem_data_in;
        got_err = mem_err;
        check("data", mem_data_in, exp_d);
        check("err", 32'(mem_err), 32'(bad));
        if (we && !bad)
            for (int i = 0; i < n; i++) ref_mem[ref_idx(addr, i)] = data[i*8 +: 8];
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_ready", 32'(mem_ready), 32'd0);
            check("hold_data", mem_data_in, 32'd0);
        end
        mem_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("rel_ready", 32'(mem_ready), 32'd0);
            check("rel_err", 32'(mem_err), 32'd0);
        end
        $display("access we=%0d w=%0d addr=%h data=%h -> rd=%h err=%0d lat=%0d",
                 we, w, addr, data, got_data, got_err, cyc);
    endtask

    // Store at 0x30 aborted by reset 'd' edges after acceptance (d=2 is the commit edge).
    task automatic reset_abort(input int d);
        int pulses;
        pulses = 0;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h30; mem_acc_width = 2'b10;
        mem_data_out = ~{ref_mem[8'h33], ref_mem[8'h32], ref_mem[8'h31], ref_mem[8'h30]};
        @(posedge clk);
        for (int k = 1; k < d; k++) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; mem_req = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_data", mem_data_in, 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mem_ready) pulses++;
        end
        check("rst_no_pulse", 32'(pulses), 32'd0);
        $display("reset abort at accept+%0d, pulses=%0d", d, pulses);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit e;
        logic [7:0] exp_b [4];

        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0;
        mem_data_out = '0; mem_acc_width = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", 32'(mem_ready), 32'd0);
        check("reset_data", mem_data_in, 32'd0);
        check("reset_err", 32'(mem_err), 32'd0);

        for (int a = 0; a < 256; a += 4) access(1'b1, 2'b10, 32'(a), $urandom, 0, d, e);

        access(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0, d, e);
        access(1'b0, 2'b10, 32'h10, 32'h0, 0, d, e);
        check("word_10", d, 32'hDEADBEEF);
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 2'b00, 32'(32'h10 + i), 32'h0, 0, d, e);
            check("byte_1x", d, 32'(exp_b[i]));
        end
        access(1'b0, 2'b00, 32'h12, 32'h0, 0, d, e);
        check("byte_12", d, 32'h000000AD);
        access(1'b0, 2'b01, 32'h12, 32'h0, 0, d, e);
        check("half_12", d, 32'h0000DEAD);

        access(1'b1, 2'b10, 32'h40, 32'hCAFEF00D, 3, d, e);
        access(1'b0, 2'b10, 32'h40, 32'h0, 3, d, e);
        check("hold_word", d, 32'hCAFEF00D);

`ifndef MEM_MISALIGN_CHK_EN
        access(1'b1, 2'b10, 32'hFE, 32'h11223344, 0, d, e);
        check("wrap_err", 32'(e), 32'd0);
        exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 2'b00, 32'((32'hFE + i) & 32'hFF), 32'h0, 0, d, e);
            check("wrap_byte", d, 32'(exp_b[i]));
        end
`else
        access(1'b1, 2'b01, 32'h21, 32'h5A5A, 0, d, e);
        check("mis_err", 32'(e), 32'd1);
        check("mis_data", d, 32'd0);
        access(1'b0, 2'b00, 32'h21, 32'h0, 0, d, e);
        access(1'b0, 2'b00, 32'h22, 32'h0, 0, d, e);
`endif

        reset_abort(1);
        access(1'b0, 2'b10, 32'h30, 32'h0, 0, d, e);
        reset_abort(2);
        access(1'b0, 2'b00, 32'h30, 32'h0, 0, d, e);

        for (int t = 0; t < 200; t++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   (t % 3 == 0) ? $urandom : 32'($urandom_range(248, 255)),
                   $urandom, $urandom_range(0, 3), d, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter M_WIDTH, default 32: address and data width; M_WIDTH >= 32.
REQ-002 SHALL have parameter DEPTH_BYTES, default 256: byte capacity; power of two.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request acceptance to ready; LATENCY >= 1.
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port mem_req, input, 1: request valid, held by initiator until mem_ready seen.
REQ-007 SHALL have port mem_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port mem_addr, input, M_WIDTH: byte address.
REQ-009 SHALL have port mem_data_out, input, M_WIDTH: store data, low bytes used.
REQ-010 SHALL have port mem_acc_width, input, 2: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved.
REQ-011 SHALL have port mem_data_in, output, M_WIDTH: load data, valid while mem_ready = 1.
REQ-012 SHALL have port mem_ready, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port mem_err, output, 1: access fault, valid while mem_ready = 1.

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> RESP -> WAIT_REL -> IDLE.
REQ-015 IDLE: mem_req = 1 at a posedge SHALL latch mem_we, mem_addr, mem_data_out and mem_acc_width, load the counter with LATENCY-1, and enter BUSY (RESP directly if LATENCY = 1).
REQ-016 BUSY: counter SHALL decrement each cycle; at counter = 0 the access SHALL be performed and the FSM SHALL enter RESP; inputs changing during BUSY SHALL be ignored.
REQ-017 mem_ready SHALL be 1 only in RESP, exactly one cycle, starting LATENCY cycles after the accepting edge.
REQ-018 RESP SHALL always go to WAIT_REL; WAIT_REL SHALL go to IDLE at the first posedge sampling mem_req = 0; no new request SHALL be accepted before IDLE.
REQ-019 Storage SHALL be a byte array; byte index = address modulo DEPTH_BYTES; multi-byte accesses SHALL be little-endian and SHALL wrap byte-by-byte past the top.
REQ-020 Store SHALL write 1/2/4 bytes from the low bytes of the latched data at the edge entering RESP; mem_data_in SHALL be 0 for stores.
REQ-021 Load SHALL zero-extend 1/2/4 bytes into mem_data_in, registered and stable throughout RESP, 0 in all other states.
REQ-022 Width 11 SHALL be treated as 32-bit.
REQ-023 mem_err SHALL be 0 outside RESP.

Reset
REQ-024 rst = 1 at a posedge SHALL force IDLE, counter 0, mem_ready 0, mem_err 0, mem_data_in 0.
REQ-025 Reset during BUSY SHALL abort the access; a store SHALL NOT be committed if rst is 1 at or before the commit edge.
REQ-026 Memory contents SHALL NOT be reset.

Configuration
REQ-027 Macro MEM_MISALIGN_CHK_EN defined: 16-bit with addr[0] = 1, or 32-bit/reserved with addr[1:0] != 0, SHALL give mem_err = 1 in RESP, no store commit, mem_data_in = 0.
REQ-028 Macro undefined: misaligned accesses SHALL be performed bytewise per REQ-019, and mem_err SHALL be tied to 0.

Structure
REQ-029 MEM_ACC_8/16/32 width codes and the FSM state encoding SHALL live in the shared core_defs package, shared with the execute stage.
REQ-030 Byte-lane extraction and merge SHALL be a sub-module mem_lane_sel; the rest is a single module.

Verification
REQ-031 LATENCY = 2: store 32-bit 0xDEADBEEF at 0x10, then load 32-bit at 0x10 -> ready 2 cycles after each accept; load returns 0xDEADBEEF; bytes 0x10..0x13 = EF, BE, AD, DE.
REQ-032 Load 8-bit at 0x12 and 16-bit at 0x12 after REQ-031 -> 0x000000AD and 0x0000DEAD.
REQ-033 mem_req held high 3 cycles after mem_ready -> exactly one ready pulse; next accept only after mem_req samples 0.
REQ-034 Store 32-bit 0x11223344 at 0xFE, macro undefined, DEPTH_BYTES = 256 -> bytes 0xFE, 0xFF, 0x00, 0x01 = 44, 33, 22, 11; mem_err = 0.
REQ-035 Macro defined: store 16-bit at 0x21 -> mem_err = 1 with ready, memory unchanged, mem_data_in = 0.
REQ-036 rst asserted one cycle after store accept at 0x30 -> no ready pulse, byte 0x30 unchanged, FSM in IDLE.
